csr_commit_ctrl: RTL and testbench
==================================

CSR_COMMIT_CTRL -- requirements
Module: csr_commit_ctrl

Interface
REQ-001 Parameters SHALL be as follows; XLEN is taken from config_pkg and is not a block parameter.
- MAX_WAIT, default 15: maximum cycles in WAIT_R before a timeout exception.
- FLUSH_ON_WRITE, default 1: pulse pipeline_flush_o after every CSR write.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk_i, in, 1: the single clock; all state updates on its rising edge.
- rst_ni, in, 1: reset; asynchronous, active-low.
- flush_i, in, 1: controller flush.
- csr_valid_i, in, 1: issue stage presents a CSR instruction.
- csr_op_i, in, 2: operation; 0=READ, 1=RW, 2=RS, 3=RC.
- csr_addr_i, in, 12: CSR address.
- csr_wdata_i, in, XLEN: source operand.
- csr_ready_o, out, 1: block can accept an instruction.
- commit_valid_i, in, 1: commit stage head is the pending CSR instruction.
- commit_ack_o, out, 1: one-cycle pulse; instruction retired.
- csr_exception_o, out, 1: valid with commit_ack_o; illegal access or timeout.
- csr_rdata_o, out, XLEN: old CSR value; valid with commit_ack_o.
- csr_req_o, out, 1: request to the CSR file.
- csr_we_o, out, 1: 1=write, 0=read.
- csr_addr_o, out, 12: CSR file address.
- csr_wdata_o, out, XLEN: CSR file write data.
- csr_gnt_i, in, 1: CSR file accepts the request in this cycle.
- csr_rvalid_i, in, 1: read data valid.
- csr_rdata_i, in, XLEN: read data.
- csr_illegal_i, in, 1: qualified by csr_rvalid_i; access is illegal.
- pipeline_flush_o, out, 1: one-cycle pulse requesting a frontend refetch.

Function
REQ-003 The FSM SHALL have the states IDLE, PEND, READ, WAIT_R, WRITE and DONE.
REQ-004 csr_ready_o SHALL be 1 only in IDLE.
REQ-005 In IDLE, csr_valid_i=1 SHALL latch op, addr and wdata and move to PEND on the next edge.
REQ-006 In PEND, commit_valid_i=1 SHALL move to READ; otherwise the FSM SHALL hold in PEND.
REQ-007 In PEND, flush_i=1 SHALL return to IDLE and discard the latched instruction, including when commit_valid_i=1 in the same cycle.
REQ-008 From READ onward, flush_i SHALL be ignored, because the instruction is committed.
REQ-009 In READ, the block SHALL drive csr_req_o=1, csr_we_o=0, csr_addr_o=latched addr, and move to WAIT_R in the cycle csr_gnt_i=1.
REQ-010 In WAIT_R, a cycle counter SHALL start at 0 and increment every cycle without csr_rvalid_i.
- csr_rvalid_i=1 SHALL capture csr_rdata_i as old_value.
- If the counter reaches MAX_WAIT first, the block SHALL set the exception flag and go to DONE.
REQ-011 csr_rvalid_i=1 with csr_illegal_i=1 SHALL set the exception flag and go to DONE with no write.
REQ-012 The new value SHALL be computed as follows.
- RW: wdata.
- RS: old_value OR wdata.
- RC: old_value AND NOT wdata.
- All results SHALL be XLEN bits wide with no extension.
REQ-013 The write SHALL be skipped, going WAIT_R->DONE, for READ ops and for RS/RC with wdata==0; RW SHALL always write.
REQ-014 In WRITE, the block SHALL drive csr_req_o=1, csr_we_o=1, csr_addr_o=latched addr, csr_wdata_o=new value, and move to DONE in the cycle csr_gnt_i=1.
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE.
- commit_ack_o=1.
- csr_rdata_o=old_value, or 0 on exception.
- csr_exception_o=exception flag.
- pipeline_flush_o=1 iff a write was performed and FLUSH_ON_WRITE=1.
REQ-016 Outside REQ-009/014, csr_req_o and csr_we_o SHALL be 0; csr_addr_o and csr_wdata_o SHALL hold their last values.
REQ-017 Back-to-back instructions SHALL be accepted no earlier than the cycle after DONE, giving a minimum occupancy of 4 cycles for READ and 5 cycles for a write with gnt and rvalid each immediate.
REQ-018 csr_valid_i while csr_ready_o=0 SHALL be ignored, and the latched instruction SHALL be unchanged.

Reset
REQ-019 On rst_ni=0, the block SHALL asynchronously enter IDLE.
- csr_ready_o=1.
- All other outputs 0.
- Latched op, addr, wdata, old_value, counter and exception flag 0.
REQ-020 A reset asserted in any state, including a granted but incomplete WRITE, SHALL abort the operation with no ack.

Verification
REQ-021 The bench SHALL cover the following scenarios.
- RW, addr 0x300, wdata 0x8, old 0x1800, gnt/rvalid immediate: write 0x8 to 0x300; ack with rdata 0x1800; flush pulse in the ack cycle; ready again 5 cycles after issue.
- RS, wdata 0: read only, no write cycle; ack with old value; pipeline_flush_o=0.
- RC, old 0xFF, wdata 0x0F, gnt delayed 3 cycles in WRITE: csr_wdata_o=0xF0 held stable until gnt; exactly one ack.
- flush_i in PEND with commit_valid_i=1 in the same cycle: return to IDLE; no csr_req_o, no ack. flush_i in WAIT_R: ignored; ack still occurs.
- csr_rvalid_i never asserted: ack with csr_exception_o=1 and csr_rdata_o=0 after MAX_WAIT=15 cycles in WAIT_R; no write.
- csr_illegal_i=1 on read: exception ack, no write. rst_ni pulsed low mid-WRITE: all outputs 0 and ready=1 immediately, with no ack.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration constants for the CSR datapath.
//   XLEN : width of CSR data, operands and read-back values.
package config_pkg;
  parameter int XLEN = 32;
endpackage

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl
// Sequences one CSR instruction at a time from issue to retirement: latches the
// instruction, waits for the commit stage, reads the old CSR value, optionally
// writes the modified value, then retires it with a one-cycle ack.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : controller flush (honoured only before commit)
//   csr_valid_i/op/addr/wdata, csr_ready_o : issue-side handshake
//   commit_valid_i         : commit head is the pending CSR instruction
//   commit_ack_o, csr_exception_o, csr_rdata_o : retirement result (one pulse)
//   csr_req_o/we/addr/wdata, csr_gnt_i : request channel to the CSR file
//   csr_rvalid_i, csr_rdata_i, csr_illegal_i : read response from the CSR file
//   pipeline_flush_o       : refetch request after a CSR write
//
// state  | meaning
// IDLE   | ready for a new instruction
// PEND   | instruction latched, waiting for commit (flushable)
// READ   | read request outstanding until granted
// WAIT_R | waiting for read data, bounded by MAX_WAIT
// WRITE  | write request outstanding until granted
// DONE   | one-cycle retirement (ack, result, optional flush)
module csr_commit_ctrl
  import config_pkg::*;
#(
  parameter int unsigned MAX_WAIT       = 15,
  parameter bit          FLUSH_ON_WRITE = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            csr_valid_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            csr_ready_o,
  input  logic            commit_valid_i,
  output logic            commit_ack_o,
  output logic            csr_exception_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_req_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic            csr_gnt_i,
  input  logic            csr_rvalid_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  input  logic            csr_illegal_i,
  output logic            pipeline_flush_o
);

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  localparam int          CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PEND, S_READ, S_WAIT_R, S_WRITE, S_DONE
  } state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] old_q;
  logic [CW-1:0]   cnt_q;
  logic            exc_q;

  logic            ready_q;
  logic            ack_q;
  logic            exc_o_q;
  logic [XLEN-1:0] rdata_o_q;
  logic            req_q;
  logic            we_q;
  logic [11:0]     addr_o_q;
  logic [XLEN-1:0] wdata_o_q;
  logic            flush_o_q;

  // New value is formed from the read data arriving this cycle, so WRITE can be
  // entered directly on the rvalid edge without an extra compute state.
  logic [XLEN-1:0] new_val_d;
  logic            write_needed_d;

  always_comb begin
    new_val_d      = csr_rdata_i;
    write_needed_d = 1'b0;
    case (op_q)
      OP_RW: begin
        new_val_d      = wdata_q;
        write_needed_d = 1'b1;
      end
      OP_RS: begin
        new_val_d      = csr_rdata_i | wdata_q;
        write_needed_d = (wdata_q != '0);
      end
      OP_RC: begin
        new_val_d      = csr_rdata_i & ~wdata_q;
        write_needed_d = (wdata_q != '0);
      end
      default: begin
        new_val_d      = csr_rdata_i;
        write_needed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      old_q     <= '0;
      cnt_q     <= '0;
      exc_q     <= 1'b0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      exc_o_q   <= 1'b0;
      rdata_o_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_o_q  <= '0;
      wdata_o_q <= '0;
      flush_o_q <= 1'b0;
    end else begin
      // Retirement outputs are pulses; they are only raised on entry to DONE.
      ack_q     <= 1'b0;
      exc_o_q   <= 1'b0;
      rdata_o_q <= '0;
      flush_o_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (csr_valid_i) begin
            op_q    <= csr_op_i;
            addr_q  <= csr_addr_i;
            wdata_q <= csr_wdata_i;
            old_q   <= '0;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_PEND;
          end
        end
        S_PEND: begin
          // Flush wins over commit: the instruction never reached retirement.
          if (flush_i) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (commit_valid_i) begin
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_o_q <= addr_q;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          if (csr_gnt_i) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (csr_rvalid_i) begin
            old_q <= csr_rdata_i;
            if (csr_illegal_i) begin
              exc_q   <= 1'b1;
              ack_q   <= 1'b1;
              exc_o_q <= 1'b1;
              state_q <= S_DONE;
            end else if (write_needed_d) begin
              req_q     <= 1'b1;
              we_q      <= 1'b1;
              wdata_o_q <= new_val_d;
              state_q   <= S_WRITE;
            end else begin
              ack_q     <= 1'b1;
              rdata_o_q <= csr_rdata_i;
              state_q   <= S_DONE;
            end
          end else if (cnt_q == CNT_LAST) begin
            // MAX_WAIT cycles elapsed with no response.
            cnt_q   <= cnt_q + CW'(1);
            exc_q   <= 1'b1;
            ack_q   <= 1'b1;
            exc_o_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          if (csr_gnt_i) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            ack_q     <= 1'b1;
            exc_o_q   <= exc_q;
            rdata_o_q <= old_q;
            flush_o_q <= FLUSH_ON_WRITE;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_ready_o      = ready_q;
  assign commit_ack_o     = ack_q;
  assign csr_exception_o  = exc_o_q;
  assign csr_rdata_o      = rdata_o_q;
  assign csr_req_o        = req_q;
  assign csr_we_o         = we_q;
  assign csr_addr_o       = addr_o_q;
  assign csr_wdata_o      = wdata_o_q;
  assign pipeline_flush_o = flush_o_q;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed scenarios followed by random
// transactions. The bench plays issue stage, commit stage and CSR file, and
// predicts each transaction's result and retirement cycle from the op rules
// and the handshake delays it chose.
module tb_csr_commit_ctrl;
  import config_pkg::*;

  localparam int MAX_WAIT = 15;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            csr_valid_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic            csr_ready_o;
  logic            commit_valid_i;
  logic            commit_ack_o;
  logic            csr_exception_o;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_req_o;
  logic            csr_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            csr_gnt_i;
  logic            csr_rvalid_i;
  logic [XLEN-1:0] csr_rdata_i;
  logic            csr_illegal_i;
  logic            pipeline_flush_o;

  int checks = 0;
  int errors = 0;

  csr_commit_ctrl #(.MAX_WAIT(MAX_WAIT), .FLUSH_ON_WRITE(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_ready_o(csr_ready_o),
    .commit_valid_i(commit_valid_i), .commit_ack_o(commit_ack_o),
    .csr_exception_o(csr_exception_o), .csr_rdata_o(csr_rdata_o),
    .csr_req_o(csr_req_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_gnt_i(csr_gnt_i),
    .csr_rvalid_i(csr_rvalid_i), .csr_rdata_i(csr_rdata_i),
    .csr_illegal_i(csr_illegal_i), .pipeline_flush_o(pipeline_flush_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, csr_ready_o, 1);
    chk({tag, "_ack"}, commit_ack_o, 0);
    chk({tag, "_exc"}, csr_exception_o, 0);
    chk({tag, "_rdata"}, csr_rdata_o, 0);
    chk({tag, "_req"}, csr_req_o, 0);
    chk({tag, "_we"}, csr_we_o, 0);
    chk({tag, "_addr"}, csr_addr_o, 0);
    chk({tag, "_wdata"}, csr_wdata_o, 0);
    chk({tag, "_pflush"}, pipeline_flush_o, 0);
  endtask

  // cd: cycles commit_valid is withheld in PEND; gr/gw: cycles before read/write
  // grant; rd: cycles in WAIT_R before rvalid (>= MAX_WAIT means never);
  // flush_t: cycle (1 = first PEND cycle) flush_i is raised, 0 = none;
  // rst_mid: pull reset in the second cycle of the write request (needs gw >= 2).
  task automatic run_txn(input logic [1:0] op, input logic [11:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] old,
                         input int cd, input int gr, input int rd, input bit ill,
                         input int gw, input int flush_t, input bit rst_mid);
    bit abort, timeout, exc, wr;
    logic [XLEN-1:0] exp_new, exp_rdata;
    int w_cycles, done_t, t, tg, rreq, wreq, acks, writes, flushes;

    abort   = (flush_t >= 1) && (flush_t <= cd + 1);
    timeout = (rd >= MAX_WAIT);
    exc     = timeout || ill;
    case (op)
      2'd1:    exp_new = wdata;
      2'd2:    exp_new = old | wdata;
      2'd3:    exp_new = old & ~wdata;
      default: exp_new = old;
    endcase
    wr        = !exc && ((op == 2'd1) || ((op != 2'd0) && (wdata != '0)));
    w_cycles  = timeout ? MAX_WAIT : rd + 1;
    done_t    = (cd + 1) + (gr + 1) + w_cycles + (wr ? gw + 1 : 0) + 1;
    exp_rdata = exc ? '0 : old;

    csr_valid_i    = 1'b1;
    csr_op_i       = op;
    csr_addr_i     = addr;
    csr_wdata_i    = wdata;
    flush_i        = 1'b0;
    commit_valid_i = 1'b0;
    csr_gnt_i      = 1'b0;
    csr_rvalid_i   = 1'b0;
    @(posedge clk_i); #1;
    t = 1; tg = 0; rreq = 0; wreq = 0; acks = 0; writes = 0; flushes = 0;

    while (1) begin
      if (t == 1) chk("ready_busy", csr_ready_o, 0);
      if (!csr_req_o) chk("we_without_req", csr_we_o, 0);
      if (abort) begin
        chk("abort_req", csr_req_o, 0);
        chk("abort_ack", commit_ack_o, 0);
        if (t == flush_t + 1) begin
          chk("abort_ready", csr_ready_o, 1);
          break;
        end
      end else begin
        if (rst_mid && csr_req_o && csr_we_o && wreq == 1) begin
          rst_ni = 1'b0;
          #1;
          chk_reset_outputs("rst_mid");
          chk("rst_mid_no_ack", acks, 0);
          csr_valid_i = 1'b0; commit_valid_i = 1'b0; csr_gnt_i = 1'b0;
          csr_rvalid_i = 1'b0; flush_i = 1'b0;
          #2 rst_ni = 1'b1;
          return;
        end
        if (commit_ack_o) begin
          acks++;
          chk("ack_cycle", t, done_t);
          chk("ack_rdata", csr_rdata_o, exp_rdata);
          chk("ack_exc", csr_exception_o, exc);
          chk("ack_pflush", pipeline_flush_o, wr);
        end
        if (pipeline_flush_o) flushes++;
        if (csr_req_o) chk("req_addr", csr_addr_o, addr);
        if (csr_req_o && csr_we_o) chk("write_data", csr_wdata_o, exp_new);
        if (t == done_t + 1) begin
          chk("ready_after", csr_ready_o, 1);
          chk("ack_count", acks, 1);
          chk("write_count", writes, wr);
          chk("pflush_count", flushes, wr);
          break;
        end
      end
      if (t > 200) begin
        chk("cycle_budget", t, done_t);
        break;
      end

      // Inputs for the remainder of cycle t; busy-time issue attempts are noise.
      csr_valid_i    = 1'($urandom_range(0, 1));
      csr_op_i       = 2'($urandom());
      csr_addr_i     = 12'($urandom());
      csr_wdata_i    = XLEN'($urandom());
      commit_valid_i = (t >= cd + 1);
      flush_i        = (t == flush_t);
      csr_gnt_i      = 1'b0;
      if (csr_req_o && !csr_we_o) begin
        csr_gnt_i = (rreq == gr);
        if (csr_gnt_i) tg = t;
        rreq++;
      end else if (csr_req_o && csr_we_o) begin
        csr_gnt_i = (wreq == gw);
        if (csr_gnt_i) writes++;
        wreq++;
      end
      if (tg > 0 && !timeout && (t - tg - 1) == rd) begin
        csr_rvalid_i  = 1'b1;
        csr_rdata_i   = old;
        csr_illegal_i = ill;
      end else begin
        csr_rvalid_i  = 1'b0;
        csr_rdata_i   = XLEN'($urandom());
        csr_illegal_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk_i); #1;
      t++;
    end
    csr_valid_i    = 1'b0;
    commit_valid_i = 1'b0;
    flush_i        = 1'b0;
    csr_gnt_i      = 1'b0;
    csr_rvalid_i   = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; csr_valid_i = 1'b0; csr_op_i = '0;
    csr_addr_i = '0; csr_wdata_i = '0; commit_valid_i = 1'b0; csr_gnt_i = 1'b0;
    csr_rvalid_i = 1'b0; csr_rdata_i = '0; csr_illegal_i = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // RW with immediate handshakes: writes 0x8, retires old 0x1800, 5-cycle occupancy.
    run_txn(2'd1, 12'h300, 32'h8, 32'h1800, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    // RS with zero operand: read only.
    run_txn(2'd2, 12'h341, 32'h0, 32'hCAFE, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    // RC with write grant held off 3 cycles: 0xF0 held stable.
    run_txn(2'd3, 12'h304, 32'h0F, 32'hFF, 0, 0, 0, 1'b0, 3, 0, 1'b0);
    // Plain READ with delays everywhere.
    run_txn(2'd0, 12'hC00, 32'h1234, 32'h55AA, 2, 1, 3, 1'b0, 0, 0, 1'b0);
    // Flush coinciding with commit in PEND, immediate and delayed commit.
    run_txn(2'd1, 12'h300, 32'h1, 32'h2, 0, 0, 0, 1'b0, 0, 1, 1'b0);
    run_txn(2'd1, 12'h300, 32'h1, 32'h2, 2, 0, 0, 1'b0, 0, 3, 1'b0);
    // Flush in WAIT_R is ignored.
    run_txn(2'd2, 12'h300, 32'h10, 32'h1, 0, 0, 2, 1'b0, 0, 3, 1'b0);
    // No read response: timeout exception.
    run_txn(2'd1, 12'h305, 32'h77, 32'h99, 0, 0, 99, 1'b0, 0, 0, 1'b0);
    // Read response in the last permitted WAIT_R cycle.
    run_txn(2'd1, 12'h305, 32'h77, 32'h99, 0, 0, MAX_WAIT - 1, 1'b0, 0, 0, 1'b0);
    // Illegal access: exception, no write.
    run_txn(2'd1, 12'h7FF, 32'h3, 32'h4, 0, 1, 1, 1'b1, 0, 0, 1'b0);
    // Reset in the middle of a granted-pending WRITE, then recovery.
    run_txn(2'd1, 12'h300, 32'hABCD, 32'h1, 0, 0, 0, 1'b0, 5, 0, 1'b1);
    @(posedge clk_i); #1;
    chk("post_reset_ready", csr_ready_o, 1);
    run_txn(2'd3, 12'h300, 32'hF000_000F, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [XLEN-1:0] wd;
      int rdly, ft;
      wd   = ($urandom_range(0, 3) == 0) ? '0 : XLEN'($urandom());
      rdly = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      ft   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_txn(2'($urandom()), 12'($urandom()), wd, XLEN'($urandom()),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rdly,
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), ft, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
